// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Works on magnitudes for 32 steps, then applies the sign correction in FIX.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] busA,
   input  logic [WIDTH-1:0] busB,
   input  logic             hi_we,
   input  logic             lo_we,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
);
   localparam int CW = $clog2(WIDTH) + 1;
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
   state_t state, nxt;
   logic [CW-1:0] cnt;
   logic [2*WIDTH-1:0] p, p_step, p_fix;
   logic [WIDTH-1:0] b, ma, mb, q_fix, r_fix;
   logic [WIDTH:0] sum, rem_sh, rem_diff;
   logic sa, sb, dv, sa_in, sb_in, accept;
   always_comb begin
      accept = (state == IDLE) && start;
      sa_in = !op[0] && busA[WIDTH-1];
      sb_in = !op[0] && busB[WIDTH-1];
      ma = sa_in ? -busA : busA;
      mb = sb_in ? -busB : busB;
      sum = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, (p[0] ? b : {WIDTH{1'b0}})};
      rem_sh = {p[2*WIDTH-1:WIDTH], p[WIDTH-1]};
      rem_diff = rem_sh - {1'b0, b};
      // restoring division keeps the remainder in the upper half, quotient bits shift into the lower half
      p_step = dv ? ((rem_sh >= {1'b0, b}) ? {rem_diff[WIDTH-1:0], p[WIDTH-2:0], 1'b1}
                                            : {rem_sh[WIDTH-1:0], p[WIDTH-2:0], 1'b0})
                  : {sum, p[WIDTH-1:1]};
      p_fix = (sa ^ sb) ? -p : p;
      q_fix = (sa ^ sb) ? -p[WIDTH-1:0] : p[WIDTH-1:0];
      r_fix = sa ? -p[2*WIDTH-1:WIDTH] : p[2*WIDTH-1:WIDTH];
      nxt = (state == IDLE) ? (start ? CALC : IDLE) :
            (state == CALC) ? ((cnt == CW'(WIDTH-1)) ? FIX : CALC) : IDLE;
      busy = (state != IDLE);
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= nxt;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hi <= '0;
         lo <= '0;
         p <= '0;
         b <= '0;
         sa <= 1'b0;
         sb <= 1'b0;
         dv <= 1'b0;
         cnt <= '0;
         done <= 1'b0;
      end else begin
         done <= (state == FIX);
         if (accept) begin
            p <= {{WIDTH{1'b0}}, ma};
            b <= mb;
            sa <= sa_in;
            sb <= sb_in;
            dv <= op[1];
            cnt <= '0;
         end else if (state == IDLE) begin
            if (hi_we) hi <= busA;
            if (lo_we) lo <= busA;
         end
         if (state == CALC) begin
            p <= p_step;
            cnt <= cnt + 1'b1;
         end
         // a zero divisor yields an all-ones quotient; the remainder is the dividend itself
         if (state == FIX) begin
            if (dv) begin
               hi <= r_fix;
               lo <= (b == '0) ? {WIDTH{1'b1}} : q_fix;
            end else
               {hi, lo} <= p_fix;
         end
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit arithmetic, latency, HI/LO writes and reset.
module tb_muldiv_unit;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
   logic [1:0] op = 2'b00;
   logic [31:0] busA = '0, busB = '0, hi, lo;
   logic busy, done;
   int cmp = 0, err = 0;
   localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .busA(busA), .busB(busB),
      .hi_we(hi_we), .lo_we(lo_we), .hi(hi), .lo(lo), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp++;
      assert (obs === exp) else begin
         err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic go(input logic [1:0] o, input logic [31:0] a, input logic [31:0] bb);
      @(negedge clk);
      op = o; busA = a; busB = bb; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0; busA = 32'h5555_AAAA; busB = 32'h0F0F_0F0F;
   endtask

   task automatic finish(input string tag, input int nexp, input logic [31:0] ehi, input logic [31:0] elo);
      int n = 0;
      @(negedge clk);
      while (busy && n < 100) begin
         chk({tag, "_nodone"}, {31'b0, done}, 32'd0);
         n++;
         @(negedge clk);
      end
      chk({tag, "_busycyc"}, n, nexp);
      chk({tag, "_done"}, {31'b0, done}, 32'd1);
      chk({tag, "_hi"}, hi, ehi);
      chk({tag, "_lo"}, lo, elo);
      @(negedge clk);
      chk({tag, "_done_off"}, {31'b0, done}, 32'd0);
   endtask

   initial begin
      #12;
      chk("rst_hi", hi, 32'h0);
      chk("rst_lo", lo, 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      @(negedge clk) rst = 1'b0;

      go(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      finish("multu_max", 33, 32'hFFFF_FFFE, 32'h0000_0001);
      go(MULT, 32'hFFFF_FFFD, 32'd7);
      finish("mult_neg", 33, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      go(MULT, 32'h8000_0000, 32'h8000_0000);
      finish("mult_min", 33, 32'h4000_0000, 32'h0000_0000);
      go(DIV, 32'hFFFF_FFF9, 32'd2);
      finish("div_neg", 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      go(DIVU, 32'd7, 32'd2);
      finish("divu", 33, 32'd1, 32'd3);
      go(DIVU, 32'h1234, 32'd0);
      finish("divu_zero", 33, 32'h1234, 32'hFFFF_FFFF);
      go(DIV, 32'hFFFF_FFFB, 32'd0);
      finish("div_zero_neg", 33, 32'hFFFF_FFFB, 32'hFFFF_FFFF);
      go(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      finish("div_ovf", 33, 32'h0, 32'h8000_0000);

      @(negedge clk);
      hi_we = 1'b1; busA = 32'hA5A5_A5A5;
      @(posedge clk);
      #1 hi_we = 1'b0;
      chk("mthi", hi, 32'hA5A5_A5A5);
      chk("mthi_lo_kept", lo, 32'h8000_0000);
      @(negedge clk);
      hi_we = 1'b1; lo_we = 1'b1; busA = 32'h1357_9BDF;
      @(posedge clk);
      #1 hi_we = 1'b0; lo_we = 1'b0;
      chk("both_hi", hi, 32'h1357_9BDF);
      chk("both_lo", lo, 32'h1357_9BDF);
      @(negedge clk);
      hi_we = 1'b1; busA = 32'hA5A5_A5A5;
      @(posedge clk);
      #1 hi_we = 1'b0;
      @(negedge clk);
      hi_we = 1'b1; op = MULTU; busA = 32'd3; busB = 32'd5; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0; hi_we = 1'b0;
      chk("we_with_start", hi, 32'hA5A5_A5A5);
      repeat (3) @(negedge clk);
      start = 1'b1; lo_we = 1'b1; hi_we = 1'b1; op = DIV; busA = 32'hDEAD_BEEF; busB = 32'd9;
      @(negedge clk);
      start = 1'b0; lo_we = 1'b0; hi_we = 1'b0;
      chk("midop_hi_hold", hi, 32'hA5A5_A5A5);
      chk("midop_lo_hold", lo, 32'h1357_9BDF);
      finish("midop", 29, 32'd0, 32'd15);

      go(DIV, 32'd100, 32'd7);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("arst_hi", hi, 32'h0);
      chk("arst_lo", lo, 32'h0);
      chk("arst_busy", {31'b0, busy}, 32'd0);
      chk("arst_done", {31'b0, done}, 32'd0);
      @(negedge clk) rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("arst_idle", {31'b0, busy}, 32'd0);
      go(DIV, 32'd100, 32'd7);
      finish("after_rst", 33, 32'd2, 32'd14);
      go(DIV, 32'd100, 32'hFFFF_FFF9);
      finish("div_negdivisor", 33, 32'd2, 32'hFFFF_FFF2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
      $finish;
   end
endmodule
